csr_access_ctrl: RTL and testbench
==================================

# csr_access_ctrl

Sequencer in front of the machine-mode CSR bank. It owns the bank's single set/clear access port and shares it between two requesters:
- the execute stage's CSR instructions (CSRRW/CSRRS/CSRRC), performed as a read then a modify;
- the trap unit's entry sequence, which writes mepc, mcause and mtval on consecutive cycles.

Every bank access is one `en_o` cycle. Read data is taken combinationally from the bank in that cycle.

## Interface
- `MEPC_ADDR`, default 12'h341: mepc address.
- `MCAUSE_ADDR`, default 12'h342: mcause address.
- `MTVAL_ADDR`, default 12'h343: mtval address.
- `clk_i` in 1: clock. One clock only.
- `rst_i` in 1: reset, synchronous, active-high.
- `csr_req_i` in 1: CSR instruction request. Held high until `csr_done_o`.
- `csr_op_i` in 2: operation. 01 = RW, 10 = RS, 11 = RC, 00 = reserved (treated as illegal).
- `csr_addr_i` in 12: CSR address.
- `csr_wdata_i` in 32: rs1 or zimm operand.
- `csr_wen_i` in 1: 0 suppresses the write phase (rs1 = x0 for RS/RC).
- `csr_done_o` out 1: one-cycle completion pulse.
- `csr_rdata_o` out 32: old CSR value. Valid while `csr_done_o` is high.
- `csr_illegal_o` out 1: no bank ack on the read. Valid while `csr_done_o` is high.
- `trap_req_i` in 1: trap entry request. Held high until `trap_done_o`.
- `trap_pc_i` in 32: faulting PC.
- `trap_cause_i` in 32: mcause value.
- `trap_val_i` in 32: mtval value.
- `trap_done_o` out 1: one-cycle completion pulse.
- `en_o` out 1: bank access strobe.
- `addr_o` out 12: bank address.
- `set_o` out 32: bank set mask.
- `clear_o` out 32: bank clear mask.
- `read_i` in 32: bank read data, combinational from `addr_o`.
- `ack_i` in 1: OR of all register acks for `addr_o` while `en_o` is high.

## Operation
**States:** IDLE, CSR_RD, CSR_WR, TRAP_EPC, TRAP_CAUSE, TRAP_TVAL, RESP.

**IDLE**
- With `trap_req_i` high, latch the trap operands and go to TRAP_EPC. A trap wins over a simultaneous CSR request.
- Otherwise, with `csr_req_i` high, latch op, addr, wdata and wen, and go to CSR_RD.

**CSR_RD**
- Bank drive: `en_o`=1, `addr_o`=addr, `set_o`=`clear_o`=0.
- Capture `read_i` into the rdata register and `ack_i` into the illegal flag (illegal = !`ack_i`).
- Go to CSR_WR if `ack_i` && wen && op≠00. Otherwise go to RESP.
- Op 00 forces illegal = 1.

**CSR_WR**
- Bank drive: `en_o`=1, same address.
- RW: set = wdata, clear = ~wdata.
- RS: set = wdata, clear = 0.
- RC: set = 0, clear = wdata.
- Next state is RESP.

**Trap sequence**
- TRAP_EPC writes `trap_pc_i`.
- TRAP_CAUSE writes `trap_cause_i`.
- TRAP_TVAL writes `trap_val_i`.
- Each step uses RW semantics (set = v, clear = ~v) at its address parameter.
- `ack_i` is ignored in these states.
- Next state after TRAP_TVAL is RESP.

**RESP**
- Pulse `csr_done_o` or `trap_done_o`, according to the requester that was served.
- Return to IDLE.

**Output values**
- `set_o`, `clear_o` and `addr_o` are 0 whenever `en_o` is 0.
- `csr_rdata_o` is 0 when illegal.

## Timing
**Reset**
- The FSM goes to IDLE.
- These outputs are 0 at reset: `en_o`, `addr_o`, `set_o`, `clear_o`, both done pulses, `csr_rdata_o`, `csr_illegal_o`.
- Reset in the middle of a sequence abandons it with no done pulse. The requester must reissue. A partially written trap triple is acceptable.

**Latency, from the acceptance cycle N in IDLE**
- CSR with write: bank cycles at N+1 and N+2; `csr_done_o` at N+3.
- CSR without write, or illegal: bank cycle at N+1; `csr_done_o` at N+2.
- Trap: bank cycles at N+1 to N+3; `trap_done_o` at N+4.

**Handshake and sharing**
- Requests are sampled only in IDLE. Operand changes after acceptance are ignored.
- A request that arrives while busy waits. The earliest acceptance is the IDLE cycle after RESP, so back-to-back accesses have a one-cycle bubble.
- A request still held high during its own done cycle is not re-accepted. Requesters drop the request on the done cycle.
- At most one `en_o` cycle per clock. The bank never sees two writers.

## Structure
- Shared package `csr_pkg` holds:
  - the op encodings (`CSR_OP_RW`/`RS`/`RC`);
  - the FSM state typedef;
  - the mepc/mcause/mtval address constants, which become the parameter defaults.
- Sub-module `csr_mask_gen` is combinational: (op, wdata) → (set, clear). Trap steps reuse it with op = RW.

## Test plan
- **CSRRS on mepc:** mepc = 0x0000_1000; request RS, addr 0x341, wdata 0x0000_0010 → bank at N+1 reads with masks 0; at N+2 set = 0x10, clear = 0; `csr_done_o` at N+3 with rdata 0x0000_1000, illegal 0; mepc = 0x0000_1010.
- **CSRRW on mepc:** request RW, wdata 0xFFFF_FFFF → set = 0xFFFF_FFFF, clear = 0; mepc reads 0xFFFF_FFFC afterwards because bits [1:0] are hard-zero.
- **Illegal address:** request to 0x7C0 with no `ack_i` → exactly one `en_o` cycle; `csr_done_o` at N+2 with illegal 1 and rdata 0; no write cycle.
- **Trap:** pc 0x8000_0104, cause 0x0000_0002, tval 0xDEAD_BEEF → bank addresses 0x341, 0x342, 0x343 with those set values on N+1 to N+3; `trap_done_o` at N+4.
- **Simultaneous requests:** `csr_req_i` and `trap_req_i` rise in the same IDLE cycle → trap served first; CSR accepted in the IDLE cycle after `trap_done_o`; CSRRC with wen = 0 → read only, done two cycles after acceptance.
- **Reset mid-trap:** assert `rst_i` during TRAP_CAUSE → next cycle is IDLE with all outputs 0 and no `trap_done_o`; a reissued trap completes normally.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR access sequencer.
//
// Contents:
//   - CSR instruction op encodings as presented on csr_op_i
//   - sequencer FSM state type
//   - default addresses of the trap-entry registers (mepc, mcause, mtval)
package csr_pkg;

  // CSR instruction operations. 2'b00 is reserved and is treated as illegal.
  localparam logic [1:0] CSR_OP_RSVD = 2'b00;
  localparam logic [1:0] CSR_OP_RW   = 2'b01;
  localparam logic [1:0] CSR_OP_RS   = 2'b10;
  localparam logic [1:0] CSR_OP_RC   = 2'b11;

  // Trap-entry register addresses; used as the top-level parameter defaults.
  localparam logic [11:0] CSR_MEPC_ADDR   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE_ADDR = 12'h342;
  localparam logic [11:0] CSR_MTVAL_ADDR  = 12'h343;

  // Sequencer states. Every state except StIdle and StResp owns the bank port.
  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StCsrRd     = 3'd1,
    StCsrWr     = 3'd2,
    StTrapEpc   = 3'd3,
    StTrapCause = 3'd4,
    StTrapTval  = 3'd5,
    StResp      = 3'd6
  } csr_state_e;

endpackage

// File: rtl/csr_mask_gen.sv
// Combinational set/clear mask generator for the CSR bank access port.
//
// Ports:
//   op_i     : operation (CSR_OP_RW / RS / RC; reserved yields empty masks)
//   wdata_i  : operand value
//   set_o    : bits to set in the target register
//   clear_o  : bits to clear in the target register
//
// RW is expressed as set = v, clear = ~v so that a single set/clear port can
// carry a full overwrite. The trap sequence reuses this block with op = RW.
module csr_mask_gen
  import csr_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] set_o,
  output logic [31:0] clear_o
);

  always_comb begin
    set_o   = '0;
    clear_o = '0;
    unique case (op_i)
      CSR_OP_RW: begin
        set_o   = wdata_i;
        clear_o = ~wdata_i;
      end
      CSR_OP_RS: begin
        set_o   = wdata_i;
      end
      CSR_OP_RC: begin
        clear_o = wdata_i;
      end
      default: begin
        set_o   = '0;
        clear_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// Sequencer in front of the machine-mode CSR bank.
//
// Owns the bank's single set/clear access port and shares it between:
//   - CSR instructions (read cycle, then an optional modify cycle)
//   - trap entry (mepc, mcause, mtval written on consecutive cycles)
// Requests are sampled only in StIdle; a trap wins over a simultaneous CSR
// request. Every access returns through StResp, which pulses the done output
// of the served requester and always leaves one idle cycle before the next
// acceptance.
//
// Ports:
//   clk_i, rst_i         : clock, synchronous active-high reset
//   csr_req_i ..         : CSR instruction request (op, addr, wdata, wen)
//   csr_done_o           : one-cycle completion pulse
//   csr_rdata_o          : old CSR value (0 when illegal), valid with done
//   csr_illegal_o        : no bank ack on the read or reserved op
//   trap_req_i ..        : trap entry request (pc, cause, tval)
//   trap_done_o          : one-cycle completion pulse
//   en_o, addr_o         : bank access strobe and address
//   set_o, clear_o       : bank set / clear masks (0 when en_o is low)
//   read_i, ack_i        : bank read data and ack, combinational from addr_o
module csr_access_ctrl
  import csr_pkg::*;
#(
  parameter logic [11:0] MEPC_ADDR   = CSR_MEPC_ADDR,
  parameter logic [11:0] MCAUSE_ADDR = CSR_MCAUSE_ADDR,
  parameter logic [11:0] MTVAL_ADDR  = CSR_MTVAL_ADDR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // CSR instruction requester
  input  logic        csr_req_i,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        csr_wen_i,
  output logic        csr_done_o,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  // Trap entry requester
  input  logic        trap_req_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_val_i,
  output logic        trap_done_o,
  // CSR bank access port
  output logic        en_o,
  output logic [11:0] addr_o,
  output logic [31:0] set_o,
  output logic [31:0] clear_o,
  input  logic [31:0] read_i,
  input  logic        ack_i
);

  csr_state_e  state_q, state_d;

  // Latched CSR instruction operands.
  logic [1:0]  op_q, op_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;

  // Latched trap operands.
  logic [31:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] tval_q, tval_d;

  // Read result of the CSR instruction.
  logic [31:0] rdata_q, rdata_d;
  logic        illegal_q, illegal_d;

  // Which requester StResp answers: 1 = trap, 0 = CSR instruction.
  logic        trap_sel_q, trap_sel_d;

  // Mask generator inputs and results.
  logic [1:0]  mask_op;
  logic [31:0] mask_wdata;
  logic [31:0] mask_set;
  logic [31:0] mask_clear;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      op_q       <= CSR_OP_RSVD;
      addr_q     <= '0;
      wdata_q    <= '0;
      wen_q      <= 1'b0;
      pc_q       <= '0;
      cause_q    <= '0;
      tval_q     <= '0;
      rdata_q    <= '0;
      illegal_q  <= 1'b0;
      trap_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wen_q      <= wen_d;
      pc_q       <= pc_d;
      cause_q    <= cause_d;
      tval_q     <= tval_d;
      rdata_q    <= rdata_d;
      illegal_q  <= illegal_d;
      trap_sel_q <= trap_sel_d;
    end
  end

  // Next-state logic and operand capture.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wen_d      = wen_q;
    pc_d       = pc_q;
    cause_d    = cause_q;
    tval_d     = tval_q;
    rdata_d    = rdata_q;
    illegal_d  = illegal_q;
    trap_sel_d = trap_sel_q;

    unique case (state_q)
      StIdle: begin
        if (trap_req_i) begin
          pc_d       = trap_pc_i;
          cause_d    = trap_cause_i;
          tval_d     = trap_val_i;
          trap_sel_d = 1'b1;
          state_d    = StTrapEpc;
        end else if (csr_req_i) begin
          op_d       = csr_op_i;
          addr_d     = csr_addr_i;
          wdata_d    = csr_wdata_i;
          wen_d      = csr_wen_i;
          trap_sel_d = 1'b0;
          state_d    = StCsrRd;
        end
      end
      StCsrRd: begin
        rdata_d   = read_i;
        // A reserved op is illegal even if the address exists.
        illegal_d = !ack_i || (op_q == CSR_OP_RSVD);
        if (ack_i && wen_q && (op_q != CSR_OP_RSVD)) begin
          state_d = StCsrWr;
        end else begin
          state_d = StResp;
        end
      end
      StCsrWr:     state_d = StResp;
      StTrapEpc:   state_d = StTrapCause;
      StTrapCause: state_d = StTrapTval;
      StTrapTval:  state_d = StResp;
      StResp:      state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Bank port drive. The read cycle leaves the mask op reserved, which yields
  // empty masks; trap steps are full overwrites.
  always_comb begin
    en_o       = 1'b0;
    addr_o     = '0;
    mask_op    = CSR_OP_RSVD;
    mask_wdata = '0;

    unique case (state_q)
      StCsrRd: begin
        en_o   = 1'b1;
        addr_o = addr_q;
      end
      StCsrWr: begin
        en_o       = 1'b1;
        addr_o     = addr_q;
        mask_op    = op_q;
        mask_wdata = wdata_q;
      end
      StTrapEpc: begin
        en_o       = 1'b1;
        addr_o     = MEPC_ADDR;
        mask_op    = CSR_OP_RW;
        mask_wdata = pc_q;
      end
      StTrapCause: begin
        en_o       = 1'b1;
        addr_o     = MCAUSE_ADDR;
        mask_op    = CSR_OP_RW;
        mask_wdata = cause_q;
      end
      StTrapTval: begin
        en_o       = 1'b1;
        addr_o     = MTVAL_ADDR;
        mask_op    = CSR_OP_RW;
        mask_wdata = tval_q;
      end
      default: begin
        en_o = 1'b0;
      end
    endcase
  end

  csr_mask_gen u_mask_gen (
    .op_i    (mask_op),
    .wdata_i (mask_wdata),
    .set_o   (mask_set),
    .clear_o (mask_clear)
  );

  assign set_o         = en_o ? mask_set : '0;
  assign clear_o       = en_o ? mask_clear : '0;

  assign csr_done_o    = (state_q == StResp) && !trap_sel_q;
  assign trap_done_o   = (state_q == StResp) && trap_sel_q;
  assign csr_rdata_o   = illegal_q ? '0 : rdata_q;
  assign csr_illegal_o = illegal_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: a small CSR bank model sits on the
// access port, and each sequence is compared against an expected bank trace,
// completion cycle and result derived from the CSR instruction semantics.
module tb_csr_access_ctrl;

  logic        clk;
  logic        rst;
  logic        bank_rst;
  logic        csr_req;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_wen;
  logic        csr_done;
  logic [31:0] csr_rdata;
  logic        csr_ill;
  logic        trap_req;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic [31:0] trap_val;
  logic        trap_done;
  logic        bank_en;
  logic [11:0] bank_addr;
  logic [31:0] bank_set;
  logic [31:0] bank_clr;
  logic [31:0] bank_read;
  logic        bank_ack;

  csr_access_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .csr_req_i     (csr_req),
    .csr_op_i      (csr_op),
    .csr_addr_i    (csr_addr),
    .csr_wdata_i   (csr_wdata),
    .csr_wen_i     (csr_wen),
    .csr_done_o    (csr_done),
    .csr_rdata_o   (csr_rdata),
    .csr_illegal_o (csr_ill),
    .trap_req_i    (trap_req),
    .trap_pc_i     (trap_pc),
    .trap_cause_i  (trap_cause),
    .trap_val_i    (trap_val),
    .trap_done_o   (trap_done),
    .en_o          (bank_en),
    .addr_o        (bank_addr),
    .set_o         (bank_set),
    .clear_o       (bank_clr),
    .read_i        (bank_read),
    .ack_i         (bank_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- CSR bank model (environment) ----------------
  localparam logic [11:0] BANK_ADDR [5] = '{12'h340, 12'h341, 12'h342, 12'h343, 12'h305};
  logic [31:0] bank [5];
  int          bidx;

  function automatic int bank_idx(input logic [11:0] a);
    for (int i = 0; i < 5; i++) if (BANK_ADDR[i] == a) return i;
    return -1;
  endfunction

  always_comb begin
    bidx      = bank_idx(bank_addr);
    bank_ack  = bank_en && (bidx >= 0);
    bank_read = (bidx >= 0) ? bank[bidx[2:0]] : 32'hBAD0_BAD0;
  end

  // mepc (index 1) has bits [1:0] hard-wired to zero.
  always @(posedge clk) begin
    if (bank_rst) begin
      for (int i = 0; i < 5; i++) bank[i] <= '0;
    end else if (bank_en && (bidx >= 0)) begin
      bank[bidx[2:0]] <= ((bank[bidx[2:0]] & ~bank_clr) | bank_set) &
                         ((bidx == 1) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
    end
  end

  // ---------------- reference state and scoreboard ----------------
  logic [31:0] ref_val [5];

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [31:0] st;
    logic [31:0] cl;
  } acc_t;

  acc_t        got_q[$];
  acc_t        exp_q[$];
  int          csr_done_n, trap_done_n, csr_done_cyc, trap_done_cyc;
  logic [31:0] got_rdata;
  logic        got_ill;
  bit          zero_ok;
  int          n_checks, n_pass;

  // First differing trace entry, -2 on length mismatch, -1 when identical.
  function automatic int trace_diff();
    if (got_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) begin
      if (got_q[i].cyc != exp_q[i].cyc || got_q[i].addr !== exp_q[i].addr ||
          got_q[i].st !== exp_q[i].st || got_q[i].cl !== exp_q[i].cl) return i;
    end
    return -1;
  endfunction

  // Watch a fixed number of cycles after the request cycle, recording every
  // bank access and done pulse; requesters drop on their own done.
  task automatic observe(input int budget, input bit scramble);
    got_q.delete();
    csr_done_n = 0; trap_done_n = 0; csr_done_cyc = -1; trap_done_cyc = -1;
    zero_ok = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (bank_en) got_q.push_back('{c, bank_addr, bank_set, bank_clr});
      else if (bank_addr !== '0 || bank_set !== '0 || bank_clr !== '0) zero_ok = 1'b0;
      if (csr_done) begin
        csr_done_n++; csr_done_cyc = c; got_rdata = csr_rdata; got_ill = csr_ill;
        csr_req = 1'b0;
      end
      if (trap_done) begin
        trap_done_n++; trap_done_cyc = c; trap_req = 1'b0;
      end
      if (scramble) begin
        csr_op = 2'($urandom); csr_addr = 12'($urandom); csr_wdata = $urandom;
        csr_wen = 1'($urandom); trap_pc = $urandom; trap_cause = $urandom;
        trap_val = $urandom;
      end
    end
    csr_req = 1'b0;
    trap_req = 1'b0;
  endtask

  // Expected CSR trace plus reference update; returns write/legal info.
  task automatic expect_csr(input int base, input logic [1:0] op, input logic [11:0] a,
                            input logic [31:0] w, input logic wen,
                            output bit legal, output bit wr, output logic [31:0] old);
    int idx;
    logic [31:0] es, ec, nv;
    idx   = bank_idx(a);
    legal = (idx >= 0) && (op != 2'b00);
    wr    = legal && wen;
    old   = (idx >= 0) ? ref_val[idx] : '0;
    case (op)
      2'b01:   begin es = w;  ec = ~w; nv = w;       end
      2'b10:   begin es = w;  ec = '0; nv = old | w;  end
      2'b11:   begin es = '0; ec = w;  nv = old & ~w; end
      default: begin es = '0; ec = '0; nv = old;      end
    endcase
    exp_q.push_back('{base + 1, a, 32'h0, 32'h0});
    if (wr) begin
      exp_q.push_back('{base + 2, a, es, ec});
      if (idx == 1) nv[1:0] = 2'b00;
      ref_val[idx] = nv;
    end
  endtask

  task automatic run_csr(input string nm, input logic [1:0] op, input logic [11:0] a,
                         input logic [31:0] w, input logic wen, input bit scramble);
    bit legal, wr;
    logic [31:0] old;
    int idx, d;
    idx = bank_idx(a);
    exp_q.delete();
    expect_csr(0, op, a, w, wen, legal, wr, old);
    csr_op = op; csr_addr = a; csr_wdata = w; csr_wen = wen; csr_req = 1'b1;
    observe(8, scramble);
    d = trace_diff();
    n_checks++;
    if (d != -1) $display("FAIL %s trace: entry %0d differs, got %0d accesses want %0d",
                          nm, d, got_q.size(), exp_q.size());
    else n_pass++;
    n_checks++;
    if (csr_done_n != 1 || csr_done_cyc != (wr ? 3 : 2))
      $display("FAIL %s done: got %0d pulses at cycle %0d want 1 at %0d",
               nm, csr_done_n, csr_done_cyc, wr ? 3 : 2);
    else n_pass++;
    n_checks++;
    if (got_rdata !== (legal ? old : 32'h0) || got_ill !== !legal)
      $display("FAIL %s result: got rdata %h illegal %b want %h %b",
               nm, got_rdata, got_ill, legal ? old : 32'h0, !legal);
    else n_pass++;
    n_checks++;
    if (!zero_ok || trap_done_n != 0)
      $display("FAIL %s idle outputs: got zero_ok %b trap_done %0d want 1 0",
               nm, zero_ok, trap_done_n);
    else n_pass++;
    if (idx >= 0) begin
      n_checks++;
      if (bank[idx] !== ref_val[idx])
        $display("FAIL %s csr value: got %h want %h", nm, bank[idx], ref_val[idx]);
      else n_pass++;
    end
  endtask

  task automatic expect_trap(input int base, input logic [31:0] pc, input logic [31:0] cause,
                             input logic [31:0] val);
    exp_q.push_back('{base + 1, 12'h341, pc, ~pc});
    exp_q.push_back('{base + 2, 12'h342, cause, ~cause});
    exp_q.push_back('{base + 3, 12'h343, val, ~val});
    ref_val[1] = pc & 32'hFFFF_FFFC;
    ref_val[2] = cause;
    ref_val[3] = val;
  endtask

  task automatic run_trap(input string nm, input logic [31:0] pc, input logic [31:0] cause,
                          input logic [31:0] val, input bit scramble);
    int d;
    exp_q.delete();
    expect_trap(0, pc, cause, val);
    trap_pc = pc; trap_cause = cause; trap_val = val; trap_req = 1'b1;
    observe(8, scramble);
    d = trace_diff();
    n_checks++;
    if (d != -1) $display("FAIL %s trace: entry %0d differs, got %0d accesses want 3",
                          nm, d, got_q.size());
    else n_pass++;
    n_checks++;
    if (trap_done_n != 1 || trap_done_cyc != 4 || csr_done_n != 0)
      $display("FAIL %s done: got %0d pulses at cycle %0d csr_done %0d want 1 at 4, 0",
               nm, trap_done_n, trap_done_cyc, csr_done_n);
    else n_pass++;
    n_checks++;
    if (!zero_ok) $display("FAIL %s idle outputs: got nonzero masks/addr want 0", nm);
    else n_pass++;
    n_checks++;
    if (bank[1] !== ref_val[1] || bank[2] !== ref_val[2] || bank[3] !== ref_val[3])
      $display("FAIL %s trap regs: got %h %h %h want %h %h %h", nm, bank[1], bank[2],
               bank[3], ref_val[1], ref_val[2], ref_val[3]);
    else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_checks++;
    if (bank_en !== 1'b0 || bank_addr !== '0 || bank_set !== '0 || bank_clr !== '0)
      $display("FAIL reset bank port: got en %b addr %h set %h clr %h want all 0",
               bank_en, bank_addr, bank_set, bank_clr);
    else n_pass++;
    n_checks++;
    if (csr_done !== 1'b0 || trap_done !== 1'b0 || csr_rdata !== '0 || csr_ill !== 1'b0)
      $display("FAIL reset responses: got done %b/%b rdata %h illegal %b want all 0",
               csr_done, trap_done, csr_rdata, csr_ill);
    else n_pass++;
  endtask

  task automatic test_csrrs_mepc();
    run_csr("preload_mepc", 2'b01, 12'h341, 32'h0000_1000, 1'b1, 1'b0);
    run_csr("csrrs_mepc", 2'b10, 12'h341, 32'h0000_0010, 1'b1, 1'b0);
    n_checks++;
    if (got_rdata !== 32'h0000_1000 || bank[1] !== 32'h0000_1010)
      $display("FAIL csrrs_mepc values: got rdata %h mepc %h want 00001000 00001010",
               got_rdata, bank[1]);
    else n_pass++;
  endtask

  task automatic test_csrrw_mepc();
    run_csr("csrrw_mepc", 2'b01, 12'h341, 32'hFFFF_FFFF, 1'b1, 1'b0);
    n_checks++;
    if (got_q.size() != 2 || got_q[1].st !== 32'hFFFF_FFFF || got_q[1].cl !== 32'h0)
      $display("FAIL csrrw_mepc masks: got %0d accesses want set ffffffff clear 0",
               got_q.size());
    else n_pass++;
    run_csr("read_mepc", 2'b10, 12'h341, 32'h0, 1'b0, 1'b0);
    n_checks++;
    if (got_rdata !== 32'hFFFF_FFFC)
      $display("FAIL mepc hard zero: got %h want fffffffc", got_rdata);
    else n_pass++;
  endtask

  task automatic test_illegal();
    run_csr("illegal_addr", 2'b01, 12'h7C0, 32'h1234_5678, 1'b1, 1'b0);
    n_checks++;
    if (got_q.size() != 1 || got_ill !== 1'b1 || got_rdata !== 32'h0)
      $display("FAIL illegal_addr summary: got %0d accesses illegal %b rdata %h want 1 1 0",
               got_q.size(), got_ill, got_rdata);
    else n_pass++;
    run_csr("reserved_op", 2'b00, 12'h340, 32'hFFFF_0000, 1'b1, 1'b0);
  endtask

  task automatic test_trap();
    run_trap("trap", 32'h8000_0104, 32'h0000_0002, 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic test_simultaneous();
    bit legal, wr;
    logic [31:0] old;
    int d;
    exp_q.delete();
    expect_trap(0, 32'h0000_2000, 32'h8000_0007, 32'h0000_00AA);
    // CSR accepted in the idle cycle after trap_done (cycle 5).
    expect_csr(5, 2'b11, 12'h342, 32'hFFFF_FFFF, 1'b0, legal, wr, old);
    trap_pc = 32'h0000_2000; trap_cause = 32'h8000_0007; trap_val = 32'h0000_00AA;
    csr_op = 2'b11; csr_addr = 12'h342; csr_wdata = 32'hFFFF_FFFF; csr_wen = 1'b0;
    trap_req = 1'b1; csr_req = 1'b1;
    observe(12, 1'b0);
    d = trace_diff();
    n_checks++;
    if (d != -1) $display("FAIL simultaneous trace: entry %0d differs, got %0d want %0d",
                          d, got_q.size(), exp_q.size());
    else n_pass++;
    n_checks++;
    if (trap_done_cyc != 4 || csr_done_cyc != 7 || trap_done_n != 1 || csr_done_n != 1)
      $display("FAIL simultaneous order: got trap@%0d csr@%0d want trap@4 csr@7",
               trap_done_cyc, csr_done_cyc);
    else n_pass++;
    n_checks++;
    if (got_rdata !== 32'h8000_0007 || got_ill !== 1'b0)
      $display("FAIL simultaneous rdata: got %h %b want 80000007 0", got_rdata, got_ill);
    else n_pass++;
  endtask

  task automatic test_reset_mid_trap();
    int spurious;
    trap_pc = 32'h0000_4444; trap_cause = 32'h0000_000B; trap_val = 32'h0000_5555;
    trap_req = 1'b1;
    @(negedge clk);  // TRAP_EPC
    @(negedge clk);  // TRAP_CAUSE
    n_checks++;
    if (bank_en !== 1'b1 || bank_addr !== 12'h342)
      $display("FAIL mid_trap position: got en %b addr %h want 1 342", bank_en, bank_addr);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bank_en !== 1'b0 || bank_addr !== '0 || bank_set !== '0 || bank_clr !== '0 ||
        trap_done !== 1'b0 || csr_done !== 1'b0 || csr_rdata !== '0 || csr_ill !== 1'b0)
      $display("FAIL mid_trap reset: got en %b addr %h done %b/%b rdata %h want all 0",
               bank_en, bank_addr, trap_done, csr_done, csr_rdata);
    else n_pass++;
    rst = 1'b0; trap_req = 1'b0;
    // mepc and mcause landed before the reset edge; mtval did not.
    ref_val[1] = 32'h0000_4444; ref_val[2] = 32'h0000_000B;
    spurious = 0;
    repeat (5) begin
      @(negedge clk);
      if (trap_done || bank_en) spurious++;
    end
    n_checks++;
    if (spurious != 0) $display("FAIL mid_trap abandon: got %0d busy cycles want 0", spurious);
    else n_pass++;
    n_checks++;
    if (bank[1] !== ref_val[1] || bank[2] !== ref_val[2] || bank[3] !== ref_val[3])
      $display("FAIL mid_trap partial: got %h %h %h want %h %h %h", bank[1], bank[2],
               bank[3], ref_val[1], ref_val[2], ref_val[3]);
    else n_pass++;
    run_trap("trap_reissue", 32'h0000_4444, 32'h0000_000B, 32'h0000_5555, 1'b0);
  endtask

  task automatic test_random();
    logic [11:0] addrs [7];
    logic [1:0]  op;
    addrs = '{12'h340, 12'h341, 12'h342, 12'h343, 12'h305, 12'h7C0, 12'hB00};
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        run_trap("rand_trap", $urandom, $urandom, $urandom, 1'b1);
      end else begin
        op = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        run_csr("rand_csr", op, addrs[$urandom_range(0, 6)], $urandom, 1'($urandom), 1'b1);
      end
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; bank_rst = 1'b1;
    csr_req = 1'b0; csr_op = '0; csr_addr = '0; csr_wdata = '0; csr_wen = 1'b0;
    trap_req = 1'b0; trap_pc = '0; trap_cause = '0; trap_val = '0;
    for (int i = 0; i < 5; i++) ref_val[i] = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0; bank_rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_csrrs_mepc();
    test_csrrw_mepc();
    test_illegal();
    test_trap();
    test_simultaneous();
    test_reset_mid_trap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
